// File: rtl/sel_mem_seq.sv
// Sequencer for the 4-bit memory-select register: per word, one sel_en cycle then a valid/ready issue cycle.
// Word cost is 2 cycles when mac_ready stays high. mac_valid holds while mac_ready is low. Outputs are registered.
module sel_mem_seq #(
    parameter int N_SEL  = 10,
    parameter int N_PASS = 3,
    parameter int PASS_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              mac_ready,
    output logic              sel_en,
    output logic [3:0]        sel_data,
    output logic              mac_valid,
    output logic              mac_last,
    output logic [PASS_W-1:0] pass_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0]        LAST_SEL  = 4'(N_SEL - 1);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(N_PASS - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        sel_idx_q, sel_idx_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic [3:0]        sel_data_q, sel_data_d;
    logic              sel_en_q, mac_valid_q, mac_last_q, busy_q, done_q;

    always_comb begin
        state_d   = state_q;
        sel_idx_d = sel_idx_q;
        pass_d    = pass_q;
        if (abort && (state_q != S_IDLE)) begin
            // Abort beats a transfer landing on the same edge.
            state_d   = S_IDLE;
            sel_idx_d = 4'd0;
            pass_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_d   = S_LOAD;
                        sel_idx_d = 4'd0;
                        pass_d    = '0;
                    end
                end
                S_LOAD: state_d = S_ISSUE;
                S_ISSUE: begin
                    if (mac_ready) begin
                        if (sel_idx_q != LAST_SEL) begin
                            sel_idx_d = sel_idx_q + 4'd1;
                            state_d   = S_LOAD;
                        end else if (pass_q != LAST_PASS) begin
                            sel_idx_d = 4'd0;
                            pass_d    = pass_q + 1'b1;
                            state_d   = S_LOAD;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // sel_data only changes on entry to LOAD, so it holds the last code otherwise.
    assign sel_data_d = (state_d == S_LOAD) ? sel_idx_d : sel_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sel_idx_q   <= 4'd0;
            pass_q      <= '0;
            sel_data_q  <= 4'd0;
            sel_en_q    <= 1'b0;
            mac_valid_q <= 1'b0;
            mac_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_idx_q   <= sel_idx_d;
            pass_q      <= pass_d;
            sel_data_q  <= sel_data_d;
            sel_en_q    <= (state_d == S_LOAD);
            mac_valid_q <= (state_d == S_ISSUE);
            mac_last_q  <= (state_d == S_ISSUE) && (sel_idx_d == LAST_SEL);
            busy_q      <= (state_d == S_LOAD) || (state_d == S_ISSUE);
            done_q      <= (state_d == S_DONE);
        end
    end

    assign sel_en    = sel_en_q;
    assign sel_data  = sel_data_q;
    assign mac_valid = mac_valid_q;
    assign mac_last  = mac_last_q;
    assign pass_idx  = pass_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
